// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: address widths, branch-condition and PC-source encodings.
package cpu_defs_pkg;

  localparam int ADDR_W   = 12;
  localparam int OFFSET_W = 8;

  typedef enum logic [1:0] {
    COND_Z  = 2'b00,
    COND_NZ = 2'b01,
    COND_C  = 2'b10,
    COND_NC = 2'b11
  } cond_e;

  // Listed lowest to highest priority.
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_PLUS1,
    SRC_OFFSET,
    SRC_CONST,
    SRC_PUSH,
    SRC_POP
  } pc_src_e;

  function automatic logic cond_met(input cond_e c, input logic z, input logic cy);
    case (c)
      COND_Z:  cond_met = z;
      COND_NZ: cond_met = ~z;
      COND_C:  cond_met = cy;
      default: cond_met = ~cy;
    endcase
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO; push/pop are applied the cycle they are seen, top reflects the stored state.
// Latency: 1 cycle write, top is combinational from registers. Push when full / pop when empty are ignored.
// Backpressure: none; the caller gates push/pop with its own enable.
module pc_return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   cnt;
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = cnt[PTR_W-1:0];
  assign rd_idx = wr_idx - PTR_W'(1);
  assign full   = (cnt == (PTR_W+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop) begin
      if (!empty) cnt <= cnt - (PTR_W+1)'(1);
    end else if (push && !full) begin
      cnt <= cnt + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !pop && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC stage: next-PC select, Z/C flag register, optional return stack enabled by `PC_STACK_EN.
// Latency: selects presented in cycle N appear on pc in cycle N+1; all outputs are registered.
// Backpressure: en=0 stalls every register (PC, flags, stack); there is no handshake.
module pc_next_unit #(
  parameter int ADDR_W      = cpu_defs_pkg::ADDR_W,
  parameter int OFFSET_W    = cpu_defs_pkg::OFFSET_W,
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sel_plus1,
  input  logic                sel_offset,
  input  logic                sel_const,
  input  logic [1:0]          cond,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [ADDR_W-1:0]   target,
  input  logic                flags_we,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                push,
  input  logic                pop,
  output logic [ADDR_W-1:0]   pc,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic                stack_err
);
  import cpu_defs_pkg::*;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] pc_nxt;
  logic              taken;
  pc_src_e           src;

  logic              pop_eff;
  logic              push_eff;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty;

  assign pc_plus1 = pc + ADDR_W'(1);
  assign off_ext  = ADDR_W'($signed(offset));
  // Registered flags only: a same-cycle flags_we cannot influence this branch.
  assign taken    = cond_met(cond_e'(cond), zero_flag, carry_flag);

`ifdef PC_STACK_EN
  logic stk_full;
  logic stk_err_q;

  assign pop_eff  = pop;
  assign push_eff = push & ~pop;

  pc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (en & push_eff),
    .pop   (en & pop_eff),
    .din   (pc_plus1),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_err_q <= 1'b0;
    end else if (en && ((pop_eff && stk_empty) || (push_eff && stk_full))) begin
      stk_err_q <= 1'b1;
    end
  end

  assign stack_err = stk_err_q;
`else
  logic unused_stack_ins;

  assign unused_stack_ins = ^{push, pop, STACK_DEPTH[0]};
  assign pop_eff          = 1'b0;
  assign push_eff         = 1'b0;
  assign stk_top          = '0;
  assign stk_empty        = 1'b1;
  assign stack_err        = 1'b0;
`endif

  always_comb begin
    src = SRC_HOLD;
    if (pop_eff)         src = SRC_POP;
    else if (push_eff)   src = SRC_PUSH;
    else if (sel_const)  src = SRC_CONST;
    else if (sel_offset) src = SRC_OFFSET;
    else if (sel_plus1)  src = SRC_PLUS1;
  end

  always_comb begin
    pc_nxt = pc;
    case (src)
      SRC_POP:    pc_nxt = stk_empty ? pc_plus1 : stk_top;
      SRC_PUSH:   pc_nxt = target;
      SRC_CONST:  pc_nxt = target;
      SRC_OFFSET: pc_nxt = taken ? pc + off_ext : pc_plus1;
      SRC_PLUS1:  pc_nxt = pc_plus1;
      default:    pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (en && flags_we) begin
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end

`ifndef SYNTHESIS
  sel_onehot_a: assert property (@(posedge clk) disable iff (rst)
      $onehot0({sel_plus1, sel_offset, sel_const}))
    else $error("pc_next_unit: more than one sel_* asserted");
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_next_unit;
  localparam int AW    = 12;
  localparam int OW    = 8;
  localparam int DEPTH = 8;
`ifdef PC_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sel_plus1, sel_offset, sel_const;
  logic [1:0]    cond;
  logic [OW-1:0] offset;
  logic [AW-1:0] target;
  logic          flags_we, alu_zero, alu_carry;
  logic          push, pop;
  logic [AW-1:0] pc;
  logic          zero_flag, carry_flag, stack_err;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference state
  int m_pc;
  bit m_z, m_c, m_err;
  int m_stk[$];

  pc_next_unit #(.ADDR_W(AW), .OFFSET_W(OW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .sel_plus1(sel_plus1), .sel_offset(sel_offset), .sel_const(sel_const),
    .cond(cond), .offset(offset), .target(target),
    .flags_we(flags_we), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .push(push), .pop(pop),
    .pc(pc), .zero_flag(zero_flag), .carry_flag(carry_flag), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    en = 1'b1; sel_plus1 = 1'b0; sel_offset = 1'b0; sel_const = 1'b0;
    cond = 2'b00; offset = '0; target = '0;
    flags_we = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_err = 0;
    m_stk.delete();
  endtask

  // Architectural rules applied to whatever inputs are present at the edge.
  task automatic model_edge();
    int nxt;
    int off;
    bit tk;
    if (!en) return;
    off = int'(offset);
    if (off >= (1 << (OW - 1))) off -= (1 << OW);
    case (cond)
      2'd0:    tk = m_z;
      2'd1:    tk = !m_z;
      2'd2:    tk = m_c;
      default: tk = !m_c;
    endcase
    nxt = m_pc;
    if (STK_EN && pop) begin
      if (m_stk.size() == 0) begin nxt = m_pc + 1; m_err = 1; end
      else nxt = m_stk.pop_back();
    end else if (STK_EN && push) begin
      if (m_stk.size() >= DEPTH) m_err = 1;
      else m_stk.push_back((m_pc + 1) % (1 << AW));
      nxt = int'(target);
    end else if (sel_const)  nxt = int'(target);
    else if (sel_offset)     nxt = tk ? m_pc + off : m_pc + 1;
    else if (sel_plus1)      nxt = m_pc + 1;
    m_pc = ((nxt % (1 << AW)) + (1 << AW)) % (1 << AW);
    if (flags_we) begin m_z = alu_zero; m_c = alu_carry; end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Mid-cycle asynchronous reset pulse, released before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; model_reset(); #3;
    n_checks++; if (pc !== 12'h000) begin n_errs++; $display("FAIL reset_pc: got %h want 000", pc); end
    n_checks++; if (zero_flag !== 1'b0) begin n_errs++; $display("FAIL reset_z: got %b want 0", zero_flag); end
    n_checks++; if (carry_flag !== 1'b0) begin n_errs++; $display("FAIL reset_c: got %b want 0", carry_flag); end
    n_checks++; if (stack_err !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b want 0", stack_err); end
    rst = 1'b0;
    sel_const = 1'b1; target = 12'h035; step(); idle();
    n_checks++; if (pc !== 12'h035) begin n_errs++; $display("FAIL pre_rst_pc: got %h want 035", pc); end
    #2 rst = 1'b1; model_reset(); #1;
    n_checks++; if (pc !== 12'h000) begin n_errs++; $display("FAIL async_rst_pc: got %h want 000", pc); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      sel_plus1 = 1'b1; step();
      n_checks++; if (pc !== AW'(i)) begin n_errs++; $display("FAIL seq_plus1_%0d: got %h want %h", i, pc, AW'(i)); end
    end
    idle();
  endtask

  task automatic test_branch();
    idle(); sel_const = 1'b1; target = 12'h010; flags_we = 1'b1; alu_zero = 1'b1; step(); idle();
    n_checks++; if (zero_flag !== 1'b1) begin n_errs++; $display("FAIL flag_latch_z: got %b want 1", zero_flag); end
    sel_offset = 1'b1; cond = 2'b00; offset = 8'h05; step(); idle();
    n_checks++; if (pc !== 12'h015) begin n_errs++; $display("FAIL br_z_taken: got %h want 015", pc); end
    sel_const = 1'b1; target = 12'h010; step(); idle();
    sel_offset = 1'b1; cond = 2'b01; offset = 8'h05; step(); idle();
    n_checks++; if (pc !== 12'h011) begin n_errs++; $display("FAIL br_nz_not_taken: got %h want 011", pc); end
    sel_const = 1'b1; target = 12'h010; step(); idle();
    sel_offset = 1'b1; cond = 2'b00; offset = 8'h05; flags_we = 1'b1; alu_zero = 1'b0; alu_carry = 1'b1; step(); idle();
    n_checks++; if (pc !== 12'h015) begin n_errs++; $display("FAIL br_old_flag: got %h want 015", pc); end
    n_checks++; if (zero_flag !== 1'b0 || carry_flag !== 1'b1) begin n_errs++; $display("FAIL flag_update: got z=%b c=%b want z=0 c=1", zero_flag, carry_flag); end
    sel_offset = 1'b1; cond = 2'b10; offset = 8'h10; step(); idle();
    n_checks++; if (pc !== 12'h025) begin n_errs++; $display("FAIL br_c_taken: got %h want 025", pc); end
  endtask

  task automatic test_wrap();
    idle(); sel_const = 1'b1; target = 12'hFFF; flags_we = 1'b1; alu_zero = 1'b1; step(); idle();
    sel_plus1 = 1'b1; step(); idle();
    n_checks++; if (pc !== 12'h000) begin n_errs++; $display("FAIL wrap_plus1: got %h want 000", pc); end
    sel_const = 1'b1; target = 12'h002; step(); idle();
    sel_offset = 1'b1; cond = 2'b00; offset = 8'hFC; step(); idle();
    n_checks++; if (pc !== 12'hFFE) begin n_errs++; $display("FAIL neg_offset: got %h want FFE", pc); end
    sel_const = 1'b1; target = 12'hABC; step(); idle();
    n_checks++; if (pc !== 12'hABC) begin n_errs++; $display("FAIL const_jump: got %h want ABC", pc); end
  endtask

  task automatic test_stall();
    // Entering with pc=ABC, Z=1, C=0.
    idle(); en = 1'b0; sel_const = 1'b1; target = 12'h123;
    flags_we = 1'b1; alu_zero = 1'b0; alu_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pc !== 12'hABC || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
        n_errs++; $display("FAIL stall_hold_%0d: got pc=%h z=%b c=%b want pc=ABC z=1 c=0", i, pc, zero_flag, carry_flag);
      end
    end
    en = 1'b1; step(); idle();
    n_checks++;
    if (pc !== 12'h123 || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
      n_errs++; $display("FAIL stall_release: got pc=%h z=%b c=%b want pc=123 z=0 c=1", pc, zero_flag, carry_flag);
    end
  endtask

`ifdef PC_STACK_EN
  task automatic test_stack();
    logic [AW-1:0] tgt;
    idle(); do_reset();
    pop = 1'b1; step(); idle();
    n_checks++; if (pc !== 12'h001 || stack_err !== 1'b1) begin n_errs++; $display("FAIL pop_empty: got pc=%h err=%b want pc=001 err=1", pc, stack_err); end
    do_reset();
    n_checks++; if (stack_err !== 1'b0) begin n_errs++; $display("FAIL err_clear_rst: got %b want 0", stack_err); end
    sel_const = 1'b1; target = 12'h100; step(); idle();
    push = 1'b1; target = 12'h200; step();
    n_checks++; if (pc !== 12'h200) begin n_errs++; $display("FAIL call1: got %h want 200", pc); end
    target = 12'h300; step(); idle();
    n_checks++; if (pc !== 12'h300) begin n_errs++; $display("FAIL call2: got %h want 300", pc); end
    pop = 1'b1; step();
    n_checks++; if (pc !== 12'h201) begin n_errs++; $display("FAIL ret1: got %h want 201", pc); end
    step(); idle();
    n_checks++; if (pc !== 12'h101 || stack_err !== 1'b0) begin n_errs++; $display("FAIL ret2: got pc=%h err=%b want pc=101 err=0", pc, stack_err); end
    for (int i = 0; i < 9; i++) begin
      tgt = 12'h050 + AW'(i * 16);
      push = 1'b1; target = tgt; step();
      n_checks++;
      if (pc !== tgt || stack_err !== (i == 8)) begin
        n_errs++; $display("FAIL push_fill_%0d: got pc=%h err=%b want pc=%h err=%b", i, pc, stack_err, tgt, (i == 8));
      end
    end
    push = 1'b1; pop = 1'b1; target = 12'h7FF; step(); idle();
    n_checks++; if (pc !== 12'h0B1) begin n_errs++; $display("FAIL push_pop_same: got %h want 0B1", pc); end
    pop = 1'b1; step(); idle();
    n_checks++; if (pc !== 12'h0A1) begin n_errs++; $display("FAIL pop_after_both: got %h want 0A1", pc); end
  endtask
`else
  task automatic test_no_stack();
    idle(); do_reset();
    sel_plus1 = 1'b1; push = 1'b1; pop = 1'b1; target = 12'h400; step(); idle();
    n_checks++; if (pc !== 12'h001) begin n_errs++; $display("FAIL nostk_plus1: got %h want 001", pc); end
    sel_const = 1'b1; push = 1'b1; target = 12'h777; step(); idle();
    n_checks++; if (pc !== 12'h777) begin n_errs++; $display("FAIL nostk_const: got %h want 777", pc); end
    pop = 1'b1; step(); idle();
    n_checks++; if (pc !== 12'h777) begin n_errs++; $display("FAIL nostk_pop_hold: got %h want 777", pc); end
    n_checks++; if (stack_err !== 1'b0) begin n_errs++; $display("FAIL nostk_err: got %b want 0", stack_err); end
  endtask
`endif

  task automatic test_random();
    int s;
    logic [AW-1:0] exp_pc;
    idle(); do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      en         = ($urandom_range(0, 7) != 0);
      s          = $urandom_range(0, 7);
      sel_plus1  = (s <= 2);
      sel_offset = (s == 3 || s == 4 || s == 5);
      sel_const  = (s == 6);
      cond       = 2'($urandom_range(0, 3));
      offset     = OW'($urandom);
      target     = AW'($urandom);
      flags_we   = $urandom_range(0, 2) == 0;
      alu_zero   = 1'($urandom);
      alu_carry  = 1'($urandom);
      push       = $urandom_range(0, 5) == 0;
      pop        = $urandom_range(0, 6) == 0;
      step();
      exp_pc = m_pc[AW-1:0];
      n_checks++;
      if (pc !== exp_pc || zero_flag !== m_z || carry_flag !== m_c || stack_err !== m_err) begin
        n_errs++;
        $display("FAIL rand_%0d: got pc=%h z=%b c=%b err=%b want pc=%h z=%b c=%b err=%b",
                 i, pc, zero_flag, carry_flag, stack_err, exp_pc, m_z, m_c, m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_wrap();
    test_stall();
`ifdef PC_STACK_EN
    test_stack();
`else
    test_no_stack();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
